platform_field: RTL

- Owns the set of jump platforms for the playfield.
- Scrolls platforms down when the doodle climbs above the scroll line, and respawns platforms that leave the bottom at random x positions.
- Once per frame, selects the landing platform under the doodle and drives it on `ground` to the doodle block.
- Renders platform pixels for the compositor from `beam_x`/`beam_y`, in the same colour/alpha format as the doodle sprite.

---
 rtl/platform_pkg.sv | 25 ++
 rtl/platform_field_lfsr16.sv | 31 +++
 rtl/platform_field.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/platform_pkg.sv
// Shared types and constants for the platform field: slot record, pass FSM states,
// and the respawn x mapping from LFSR state into the legal x window.
`timescale 1ns/1ps
package platform_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } plat_t;

    typedef enum logic [1:0] {IDLE, SCROLL, SEARCH, COMMIT} state_t;

    localparam logic [9:0]  FLOOR_Y  = 10'd767;
    localparam logic [10:0] DOODLE_H = 11'd80;

    // Folds the low LFSR byte (0..255) onto 0..span-1 with one conditional subtract.
    function automatic logic [10:0] respawnX(input logic [15:0] lfsrState,
                                             input logic [10:0] xMin,
                                             input logic [10:0] span);
        logic [10:0] r;
        r = {3'b000, lfsrState[7:0]};
        return xMin + ((r >= span) ? (r - span) : r);
    endfunction

endpackage

// File: rtl/platform_field_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only when step is high.
`timescale 1ns/1ps
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/platform_field.sv
// Platform slots for the playfield: per-frame scroll/respawn, landing search for the
// doodle, and a registered pixel path for the compositor.
`timescale 1ns/1ps
module platform_field
    import platform_pkg::*;
#(
    parameter int          NUM_PLAT    = 8,
    parameter int          PLAT_W      = 100,
    parameter int          PLAT_H      = 30,
    parameter int          SPACING     = 90,
    parameter int          FIELD_X_MIN = 301,
    parameter int          X_SPAN      = 241,
    parameter int          SCREEN_H    = 768,
    parameter int          SCROLL_LINE = 300,
    parameter int          MAX_SHIFT   = 32,
    parameter int          FPS         = 50,
    parameter int          CLK         = 50000000,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [11:0] PLAT_COLOR  = 12'h4C2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     doodle_x,
    input  logic [9:0]      doodle_y,
    input  logic [10:0]     beam_x,
    input  logic [9:0]      beam_y,
    output logic [1:0][9:0] ground,
    output logic [2:0][3:0] color,
    output logic            is_transparent,
    output logic [15:0]     score,
    output logic            fell
);

    localparam int          TICKS     = CLK / FPS;
    localparam int          CW        = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int          IW        = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [10:0] RESPAWN_W = 11'(NUM_PLAT * SPACING);
    localparam logic [10:0] SCREEN_W  = 11'(SCREEN_H);
    localparam logic [10:0] LINE_W    = 11'(SCROLL_LINE);
    localparam logic [10:0] MAXSH_W   = 11'(MAX_SHIFT);
    localparam logic [10:0] PLATW_W   = 11'(PLAT_W);
    localparam logic [10:0] PLATH_W   = 11'(PLAT_H);
    localparam logic [10:0] XMIN_W    = 11'(FIELD_X_MIN);
    localparam logic [10:0] SPAN_W    = 11'(X_SPAN);
    localparam logic [9:0]  FELL_Y    = 10'(SCREEN_H - 80);

    logic [CW-1:0] frameCnt_q;
    logic          tick;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          lastSlot;
    logic          startPass, scrollEn, searchEn, commitEn;

    logic [10:0]   shiftNew, shift_q, dx_q;
    logic [9:0]    dy_q;
    logic [15:0]   score_q;
    logic          floorActive_q, fell_q;

    plat_t         slots_q [NUM_PLAT];
    plat_t         cur, slot_d;
    logic [10:0]   ny;
    logic          respawn;
    logic [15:0]   lfsrQ;

    logic          candidate, better, found_q;
    logic [9:0]    bestX_q;
    logic [10:0]   bestY_q;
    logic [1:0][9:0] ground_q;

    logic          hit;
    logic [11:0]   color_q;
    logic          transparent_q;

    // Frame tick: one-cycle pulse as the counter wraps.
    assign tick = (frameCnt_q == CW'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            frameCnt_q <= '0;
        end else begin
            frameCnt_q <= tick ? '0 : frameCnt_q + CW'(1);
        end
    end

    assign lastSlot = (idx_q == IW'(NUM_PLAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick)     state_d = SCROLL;
            SCROLL:  if (lastSlot) state_d = SEARCH;
            SEARCH:  if (lastSlot) state_d = COMMIT;
            COMMIT:                state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        startPass = (state_q == IDLE) && tick;
        scrollEn  = (state_q == SCROLL);
        searchEn  = (state_q == SEARCH);
        commitEn  = (state_q == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if ((scrollEn || searchEn) && !lastSlot) begin
            idx_q <= idx_q + IW'(1);
        end else begin
            idx_q <= '0;
        end
    end

    always_comb begin
        shiftNew = '0;
        if ({1'b0, doodle_y} < LINE_W) begin
            shiftNew = LINE_W - {1'b0, doodle_y};
            if (shiftNew > MAXSH_W) begin
                shiftNew = MAXSH_W;
            end
        end
    end

    // Doodle position and shift are frozen for the whole pass; any scroll retires the floor.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q       <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            score_q       <= '0;
            floorActive_q <= 1'b1;
        end else if (startPass) begin
            shift_q <= shiftNew;
            dx_q    <= doodle_x;
            dy_q    <= doodle_y;
            if (shiftNew != '0) begin
                score_q       <= score_q + 16'(shiftNew);
                floorActive_q <= 1'b0;
            end
        end
    end

    lfsr16 #(.SEED(SEED)) uLfsr (
        .clk  (clk),
        .rst  (rst),
        .step (respawn),
        .q    (lfsrQ)
    );

    always_comb begin
        cur      = slots_q[idx_q];
        ny       = cur.y + shift_q;
        respawn  = scrollEn && (ny >= SCREEN_W);
        slot_d.x = respawn ? respawnX(lfsrQ, XMIN_W, SPAN_W) : cur.x;
        slot_d.y = respawn ? (ny - RESPAWN_W) : ny;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                slots_q[i].x <= 11'(FIELD_X_MIN + 40 * i);
                slots_q[i].y <= 11'(680 - SPACING * i);
            end
        end else if (scrollEn) begin
            slots_q[idx_q] <= slot_d;
        end
    end

    // Topmost landable slot wins; strict compare keeps the lower index on ties.
    always_comb begin
        candidate = searchEn
                 && (cur.x <= dx_q)
                 && (dx_q <= cur.x + PLATW_W - 11'd1)
                 && (cur.y + PLATH_W >= {1'b0, dy_q} + DOODLE_H);
        better    = candidate && (!found_q || (cur.y < bestY_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            found_q <= 1'b0;
            bestX_q <= '0;
            bestY_q <= '0;
        end else if (startPass) begin
            found_q <= 1'b0;
        end else if (better) begin
            found_q <= 1'b1;
            bestX_q <= cur.x[9:0];
            bestY_q <= cur.y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ground_q[0] <= FLOOR_Y;
            ground_q[1] <= '0;
            fell_q      <= 1'b0;
        end else if (commitEn) begin
            if (found_q) begin
                ground_q[0] <= bestY_q[9:0];
                ground_q[1] <= bestX_q;
            end else if (floorActive_q) begin
                ground_q[0] <= FLOOR_Y;
                ground_q[1] <= '0;
            end else begin
                ground_q[0] <= '0;
                ground_q[1] <= '0;
            end
            if (!floorActive_q && (dy_q >= FELL_Y)) begin
                fell_q <= 1'b1;
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if ((slots_q[i].x <= beam_x) && (beam_x < slots_q[i].x + PLATW_W)
                && (slots_q[i].y <= {1'b0, beam_y})
                && ({1'b0, beam_y} < slots_q[i].y + PLATH_W)
                && (slots_q[i].y < SCREEN_W)) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q       <= '0;
            transparent_q <= 1'b1;
        end else begin
            color_q       <= hit ? PLAT_COLOR : 12'h000;
            transparent_q <= !hit;
        end
    end

    assign ground         = ground_q;
    assign color          = color_q;
    assign is_transparent = transparent_q;
    assign score          = score_q;
    assign fell           = fell_q;

endmodule
